pixel_plot_sink: RTL and testbench

- Receiving end of the pixel-plot interface driven by the sprite and rectangle drawers.
- Accepts plot requests (x, y, colour, plot strobe) into a small FIFO and clips off-screen coordinates.
- Converts each on-screen request to a linear address and writes it into the single-port framebuffer RAM.
- Arbitrates that RAM port against the video scanout reader; scanout always has priority.

---
 rtl/draw_pkg.sv | 36 +++
 rtl/plot_fifo.sv | 67 ++++++
 rtl/pixel_plot_sink.sv | 103 ++++++++++
 tb/tb_pixel_plot_sink.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// ============================================================================
// Module      : draw_pkg
// Description : Shared screen geometry, colours, plot request type and the
//               coordinate-to-framebuffer-address helper.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package draw_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int COLOUR_W = 3;
    localparam int ADDR_W   = 17;
    localparam int X_W      = 9;
    localparam int Y_W      = 8;

    localparam logic [COLOUR_W-1:0] COL_BLACK = 3'b000;
    localparam logic [COLOUR_W-1:0] COL_WHITE = 3'b111;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } plot_req_t;

    function automatic logic [ADDR_W-1:0] coord_to_addr(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y
    );
        return ADDR_W'(y) * ADDR_W'(SCREEN_W) + ADDR_W'(x);
    endfunction

endpackage

`default_nettype wire

// File: rtl/plot_fifo.sv
// ============================================================================
// Module      : plot_fifo
// Description : Synchronous FIFO with full/empty flags, asynchronous
//               active-low reset. Head entry is visible combinationally.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module plot_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_push_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_pop_data,
    output logic              o_full,
    output logic              o_empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W:0]    r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full     = (r_count == (PTR_W+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_do_push  = i_push && !o_full;
    assign w_do_pop   = i_pop && !o_empty;
    assign o_pop_data = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/pixel_plot_sink.sv
// ============================================================================
// Module      : pixel_plot_sink
// Description : Buffers plot requests, clips off-screen pixels and writes the
//               rest into the framebuffer; scanout reads always win the port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module pixel_plot_sink
    import draw_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clock_all,
    input  logic                reset_all,
    input  logic [X_W-1:0]      plot_x,
    input  logic [Y_W-1:0]      plot_y,
    input  logic [COLOUR_W-1:0] plot_colour,
    input  logic                plot,
    output logic                plot_ready,
    input  logic                scan_req,
    input  logic [ADDR_W-1:0]   scan_addr,
    output logic                scan_valid,
    output logic [COLOUR_W-1:0] scan_data,
    output logic [ADDR_W-1:0]   fb_addr,
    output logic [COLOUR_W-1:0] fb_wdata,
    output logic                fb_we,
    input  logic [COLOUR_W-1:0] fb_rdata,
    output logic                idle,
    output logic [7:0]          clip_count
);

    plot_req_t w_push_req;
    plot_req_t w_head;
    logic      w_full;
    logic      w_empty;
    logic      w_push;
    logic      w_pop;
    logic      w_clip;

    logic [ADDR_W-1:0]   r_fb_addr;
    logic [COLOUR_W-1:0] r_fb_wdata;
    logic                r_fb_we;
    logic                r_scan_valid;
    logic [7:0]          r_clip_count;

    assign w_push_req = '{x: plot_x, y: plot_y, colour: plot_colour};
    assign w_push     = plot && !w_full;
    assign w_pop      = !scan_req && !w_empty;
    assign w_clip     = (ADDR_W'(w_head.x) >= ADDR_W'(SCREEN_W)) ||
                        (ADDR_W'(w_head.y) >= ADDR_W'(SCREEN_H));

    plot_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W ($bits(plot_req_t))
    ) u_plot_fifo (
        .clk         (clock_all),
        .rst_n       (reset_all),
        .i_push      (w_push),
        .i_push_data (w_push_req),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    // A pending write stalled by scanout is held, not lost, until the port frees up.
    always_ff @(posedge clock_all or negedge reset_all) begin
        if (!reset_all) begin
            r_fb_addr    <= '0;
            r_fb_wdata   <= '0;
            r_fb_we      <= 1'b0;
            r_scan_valid <= 1'b0;
            r_clip_count <= '0;
        end else begin
            r_scan_valid <= scan_req;
            if (!scan_req) begin
                if (w_pop && !w_clip) begin
                    r_fb_we    <= 1'b1;
                    r_fb_addr  <= coord_to_addr(w_head.x, w_head.y);
                    r_fb_wdata <= w_head.colour;
                end else begin
                    r_fb_we <= 1'b0;
                end
                if (w_pop && w_clip && (r_clip_count != 8'hFF)) begin
                    r_clip_count <= r_clip_count + 8'd1;
                end
            end
        end
    end

    assign plot_ready = !w_full;
    assign fb_addr    = scan_req ? scan_addr : r_fb_addr;
    assign fb_we      = r_fb_we && !scan_req;
    assign fb_wdata   = r_fb_wdata;
    assign scan_valid = r_scan_valid;
    assign scan_data  = r_scan_valid ? fb_rdata : '0;
    assign idle       = w_empty && !r_fb_we;
    assign clip_count = r_clip_count;

endmodule

`default_nettype wire

// File: tb/tb_pixel_plot_sink.sv
// ============================================================================
// Module      : tb_pixel_plot_sink
// Description : Directed self-checking bench for pixel_plot_sink with a
//               behavioural synchronous framebuffer RAM.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_pixel_plot_sink;

    logic        clock_all = 1'b0;
    logic        reset_all = 1'b0;
    logic [8:0]  plot_x = '0;
    logic [7:0]  plot_y = '0;
    logic [2:0]  plot_colour = '0;
    logic        plot = 1'b0;
    logic        plot_ready;
    logic        scan_req = 1'b0;
    logic [16:0] scan_addr = '0;
    logic        scan_valid;
    logic [2:0]  scan_data;
    logic [16:0] fb_addr;
    logic [2:0]  fb_wdata;
    logic        fb_we;
    logic [2:0]  fb_rdata = '0;
    logic        idle;
    logic [7:0]  clip_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [2:0]  mem [0:76799];
    logic [16:0] log_addr [$];
    logic [2:0]  log_data [$];

    pixel_plot_sink #(.FIFO_DEPTH(4)) dut (
        .clock_all   (clock_all),
        .reset_all   (reset_all),
        .plot_x      (plot_x),
        .plot_y      (plot_y),
        .plot_colour (plot_colour),
        .plot        (plot),
        .plot_ready  (plot_ready),
        .scan_req    (scan_req),
        .scan_addr   (scan_addr),
        .scan_valid  (scan_valid),
        .scan_data   (scan_data),
        .fb_addr     (fb_addr),
        .fb_wdata    (fb_wdata),
        .fb_we       (fb_we),
        .fb_rdata    (fb_rdata),
        .idle        (idle),
        .clip_count  (clip_count)
    );

    always #5 clock_all = ~clock_all;

    always @(posedge clock_all) begin
        if (fb_we && fb_addr < 17'd76800) mem[fb_addr] <= fb_wdata;
        fb_rdata <= (fb_addr < 17'd76800) ? mem[fb_addr] : 3'd0;
        if (reset_all && fb_we) begin
            log_addr.push_back(fb_addr);
            log_data.push_back(fb_wdata);
        end
    end

    task automatic step();
        @(posedge clock_all);
        #1;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (idle) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (fb_we !== 1'b0)        begin n_fail++; $display("FAIL reset_fb_we got %0d want 0", fb_we); end
        n_checks++; if (fb_addr !== 17'd0)     begin n_fail++; $display("FAIL reset_fb_addr got %0d want 0", fb_addr); end
        n_checks++; if (fb_wdata !== 3'd0)     begin n_fail++; $display("FAIL reset_fb_wdata got %0d want 0", fb_wdata); end
        n_checks++; if (scan_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_scan_valid got %0d want 0", scan_valid); end
        n_checks++; if (scan_data !== 3'd0)    begin n_fail++; $display("FAIL reset_scan_data got %0d want 0", scan_data); end
        n_checks++; if (plot_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_plot_ready got %0d want 1", plot_ready); end
        n_checks++; if (idle !== 1'b1)         begin n_fail++; $display("FAIL reset_idle got %0d want 1", idle); end
        n_checks++; if (clip_count !== 8'd0)   begin n_fail++; $display("FAIL reset_clip_count got %0d want 0", clip_count); end
        step();
        reset_all = 1'b1;
        step();
    endtask

    task automatic test_single();
        bit ok;
        log_addr.delete(); log_data.delete();
        plot = 1'b1; plot_x = 9'd10; plot_y = 8'd5; plot_colour = 3'b111;
        n_checks++; if (plot_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready got %0d want 1", plot_ready); end
        step();
        plot = 1'b0;
        step();
        n_checks++; if (fb_we !== 1'b1)      begin n_fail++; $display("FAIL single_we got %0d want 1", fb_we); end
        n_checks++; if (fb_addr !== 17'd1610) begin n_fail++; $display("FAIL single_addr got %0d want 1610", fb_addr); end
        n_checks++; if (fb_wdata !== 3'd7)   begin n_fail++; $display("FAIL single_wdata got %0d want 7", fb_wdata); end
        n_checks++; if (idle !== 1'b0)       begin n_fail++; $display("FAIL single_busy got %0d want 0", idle); end
        step();
        n_checks++; if (fb_we !== 1'b0)      begin n_fail++; $display("FAIL single_we_drop got %0d want 0", fb_we); end
        n_checks++; if (idle !== 1'b1)       begin n_fail++; $display("FAIL single_idle got %0d want 1", idle); end
        n_checks++; if (log_addr.size() != 1) begin n_fail++; $display("FAIL single_count got %0d want 1", log_addr.size()); end
        wait_idle(ok);
    endtask

    task automatic test_back_to_back();
        bit ok;
        log_addr.delete(); log_data.delete();
        for (int i = 0; i < 6; i++) begin
            plot = 1'b1; plot_x = 9'(i); plot_y = 8'd0; plot_colour = 3'(i + 1);
            n_checks++; if (plot_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready[%0d] got %0d want 1", i, plot_ready); end
            step();
        end
        plot = 1'b0;
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL b2b_idle_timeout got busy want idle"); end
        n_checks++; if (log_addr.size() != 6) begin n_fail++; $display("FAIL b2b_count got %0d want 6", log_addr.size()); end
        for (int i = 0; i < 6 && i < log_addr.size(); i++) begin
            n_checks++;
            if (log_addr[i] !== 17'(i) || log_data[i] !== 3'(i + 1)) begin
                n_fail++;
                $display("FAIL b2b_write[%0d] got addr %0d data %0d want addr %0d data %0d", i, log_addr[i], log_data[i], i, i + 1);
            end
        end
    endtask

    task automatic test_scan_priority();
        bit ok;
        log_addr.delete(); log_data.delete();
        for (int k = 0; k < 5; k++) mem[100 + k] = 3'(k + 2);
        for (int k = 0; k < 5; k++) begin
            scan_req = 1'b1; scan_addr = 17'(100 + k);
            plot = 1'b1; plot_x = 9'(20 + k); plot_y = 8'd1; plot_colour = 3'(k + 1);
            #1;
            n_checks++; if (plot_ready !== (k < 4)) begin n_fail++; $display("FAIL scan_ready[%0d] got %0d want %0d", k, plot_ready, k < 4); end
            n_checks++; if (fb_we !== 1'b0) begin n_fail++; $display("FAIL scan_no_we[%0d] got %0d want 0", k, fb_we); end
            n_checks++; if (fb_addr !== 17'(100 + k)) begin n_fail++; $display("FAIL scan_addr[%0d] got %0d want %0d", k, fb_addr, 100 + k); end
            if (k == 0) begin
                n_checks++; if (scan_valid !== 1'b0) begin n_fail++; $display("FAIL scan_valid0 got %0d want 0", scan_valid); end
            end else begin
                n_checks++;
                if (scan_valid !== 1'b1 || scan_data !== 3'(k + 1)) begin
                    n_fail++;
                    $display("FAIL scan_rdata[%0d] got valid %0d data %0d want valid 1 data %0d", k, scan_valid, scan_data, k + 1);
                end
            end
            step();
        end
        scan_req = 1'b0; plot = 1'b0;
        #1;
        n_checks++;
        if (scan_valid !== 1'b1 || scan_data !== 3'd6) begin
            n_fail++; $display("FAIL scan_rdata_last got valid %0d data %0d want valid 1 data 6", scan_valid, scan_data);
        end
        step();
        n_checks++; if (scan_valid !== 1'b0) begin n_fail++; $display("FAIL scan_valid_drop got %0d want 0", scan_valid); end
        wait_idle(ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL scan_idle_timeout got busy want idle"); end
        n_checks++; if (log_addr.size() != 4) begin n_fail++; $display("FAIL scan_write_count got %0d want 4", log_addr.size()); end
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            n_checks++;
            if (log_addr[i] !== 17'(340 + i) || log_data[i] !== 3'(i + 1)) begin
                n_fail++;
                $display("FAIL scan_write[%0d] got addr %0d data %0d want addr %0d data %0d", i, log_addr[i], log_data[i], 340 + i, i + 1);
            end
        end
    endtask

    task automatic test_clip();
        bit ok;
        log_addr.delete(); log_data.delete();
        plot = 1'b1; plot_x = 9'd320; plot_y = 8'd0;   plot_colour = 3'd1; step();
        plot_x = 9'd0;   plot_y = 8'd240; plot_colour = 3'd2; step();
        plot_x = 9'd319; plot_y = 8'd239; plot_colour = 3'd5; step();
        plot = 1'b0;
        wait_idle(ok);
        n_checks++; if (clip_count !== 8'd2) begin n_fail++; $display("FAIL clip_count got %0d want 2", clip_count); end
        n_checks++;
        if (log_addr.size() != 1 || log_addr[0] !== 17'd76799 || log_data[0] !== 3'd5) begin
            n_fail++; $display("FAIL clip_corner_write got count %0d want 1 write of 5 at 76799", log_addr.size());
        end
    endtask

    task automatic test_saturate();
        bit ok;
        log_addr.delete(); log_data.delete();
        plot = 1'b1; plot_x = 9'd400; plot_y = 8'd10; plot_colour = 3'd3;
        for (int i = 0; i < 300; i++) step();
        plot = 1'b0;
        wait_idle(ok);
        n_checks++; if (clip_count !== 8'd255) begin n_fail++; $display("FAIL clip_saturate got %0d want 255", clip_count); end
        n_checks++; if (log_addr.size() != 0) begin n_fail++; $display("FAIL clip_no_writes got %0d want 0", log_addr.size()); end
    endtask

    task automatic test_reset_mid_drain();
        plot = 1'b1; plot_y = 8'd50; plot_colour = 3'd6;
        for (int i = 0; i < 3; i++) begin
            plot_x = 9'(30 + i);
            step();
        end
        plot = 1'b0;
        n_checks++; if (fb_we !== 1'b1) begin n_fail++; $display("FAIL mid_drain_we got %0d want 1", fb_we); end
        log_addr.delete(); log_data.delete();
        reset_all = 1'b0;
        #1;
        n_checks++; if (fb_we !== 1'b0)      begin n_fail++; $display("FAIL rst_mid_we got %0d want 0", fb_we); end
        n_checks++; if (idle !== 1'b1)       begin n_fail++; $display("FAIL rst_mid_idle got %0d want 1", idle); end
        n_checks++; if (plot_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready got %0d want 1", plot_ready); end
        n_checks++; if (clip_count !== 8'd0) begin n_fail++; $display("FAIL rst_mid_clip got %0d want 0", clip_count); end
        step(); step();
        reset_all = 1'b1;
        for (int i = 0; i < 5; i++) step();
        n_checks++; if (log_addr.size() != 0) begin n_fail++; $display("FAIL rst_mid_no_writes got %0d want 0", log_addr.size()); end
        n_checks++; if (idle !== 1'b1)        begin n_fail++; $display("FAIL rst_mid_idle_after got %0d want 1", idle); end
    endtask

    initial begin
        for (int i = 0; i < 76800; i++) mem[i] = 3'd0;
        test_reset();
        test_single();
        test_back_to_back();
        test_scan_priority();
        test_clip();
        test_saturate();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
